dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of BUSY cycles without mem_ready before a timeout.
REQ-002 SHALL have port clock, input, 1, system clock.
REQ-003 SHALL have port reset, input, 1; reset is synchronous, active-high, and the clock is clock.
REQ-004 SHALL have port req_valid, input, 1, processor data-memory access request.
REQ-005 SHALL have port addr, input, [0:31], byte address; bit 31 is the LSB.
REQ-006 SHALL have port write_enable, input, 1, 1=store, 0=load.
REQ-007 SHALL have ports byte and half_word, input, 1 each; both 0 means word.
REQ-008 SHALL have port sign_extend, input, 1, load sign-extension select.
REQ-009 SHALL have port wdata, input, [0:31], store data, right-justified.
REQ-010 SHALL have port rdata, output, [0:31], aligned and extended load data.
REQ-011 SHALL have port stall, output, 1, processor hold.
REQ-012 SHALL have port err, output, 1, misalignment or timeout, valid in DONE.
REQ-013 SHALL have port mem_req, output, 1, backing-memory request.
REQ-014 SHALL have port mem_we, output, 1, backing-memory write enable.
REQ-015 SHALL have port mem_addr, output, [0:29], word address = addr[0:29].
REQ-016 SHALL have port mem_be, output, [0:3], byte enables; be[0] is bits [0:7].
REQ-017 SHALL have port mem_wdata, output, [0:31], lane-replicated store data.
REQ-018 SHALL have ports mem_rdata, input, [0:31], and mem_ready, input, 1, backing-memory completion.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-020 SHALL transition IDLE->BUSY on req_valid with an aligned address, and IDLE->DONE with err=1 on a misaligned address.
REQ-021 SHALL define alignment as: halfword requires addr[31]=0; word requires addr[30:31]=0; byte is always aligned.
REQ-022 SHALL assert stall combinationally when state=BUSY, or when state=IDLE and req_valid=1, and SHALL deassert it in DONE.
REQ-023 SHALL transition DONE->IDLE unconditionally; the processor advances on the DONE edge, and req_valid seen in DONE SHALL be ignored.
REQ-024 SHALL drive mem_req=1 only in BUSY; the addr, we, be and wdata fields SHALL be registered on the IDLE->BUSY edge and held stable while BUSY.
REQ-025 SHALL set mem_be, big-endian, as follows: byte offset k -> be[k]=1 only; halfword offset 0 -> 1100, offset 2 -> 0011; word -> 1111.
REQ-026 SHALL form mem_wdata as follows: byte = wdata[24:31] replicated 4x; halfword = wdata[16:31] replicated 2x; word = wdata.
REQ-027 SHALL, on BUSY with mem_ready=1, capture mem_rdata, go to DONE and set err=0.
REQ-028 SHALL form load rdata as follows: select lane [8k:8k+7] (byte) or [16j:16j+15] (halfword), right-justify it, then zero- or sign-extend per the latched sign_extend; word loads pass through unchanged.
REQ-029 SHALL force rdata=0 for stores and for error completions.
REQ-030 SHALL run a wait counter that clears on BUSY entry and increments each BUSY cycle without mem_ready.
REQ-031 SHALL, when the wait counter reaches MAX_WAIT, go to DONE with err=1 and drop mem_req; mem_ready arriving on that same cycle SHALL win, giving a normal completion.
REQ-032 SHALL hold rdata and err valid throughout the DONE cycle, and SHALL otherwise hold their last values.
REQ-033 SHALL take a minimum of 3 cycles per access (IDLE, BUSY, DONE) when mem_ready arrives in the first BUSY cycle.

Reset
REQ-034 SHALL, on reset, set state=IDLE, the wait counter to 0, and rdata, err, mem_req, mem_we, mem_be, mem_addr and mem_wdata to 0.
REQ-035 SHALL make stall follow REQ-022, i.e. stall=req_valid.
REQ-036 SHALL, if reset occurs during BUSY, abort the access and drop mem_req on the same edge; a mem_ready arriving in the next cycle SHALL be ignored.

Structure
REQ-037 SHALL place the state enum, the size encoding (BYTE/HALF/WORD) and the byte-enable/alignment functions in the shared package dmem_pkg.
REQ-038 SHALL place load lane extract and extension in the combinational sub-module dmem_lane_align; the FSM, counter and registers SHALL reside in dmem_ctrl.

Verification
REQ-039 SHALL verify word store: addr=0x100, wdata=0xDEADBEEF, mem_ready in the 1st BUSY cycle -> mem_addr=0x40, mem_be=1111, mem_wdata=0xDEADBEEF, stall high 2 cycles, err=0.
REQ-040 SHALL verify signed byte load: addr=0x103, sign_extend=1, mem_rdata=0x112233F0 -> rdata=0xFFFFFFF0; the same with sign_extend=0 -> rdata=0x000000F0.
REQ-041 SHALL verify halfword store: addr=0x22, wdata=0x0000ABCD -> mem_be=0011, mem_wdata=0xABCDABCD.
REQ-042 SHALL verify misalignment: word access at addr=0x102 -> no mem_req, DONE next cycle, err=1, rdata=0.
REQ-043 SHALL verify timeout: mem_ready held low -> mem_req high for exactly 15 cycles, then err=1; mem_ready on the 15th cycle -> err=0.
REQ-044 SHALL verify reset mid-BUSY: reset in the 2nd BUSY cycle -> mem_req=0 and state=IDLE next cycle; a late mem_ready produces no DONE.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: FSM states,
// access-size encoding, alignment test, byte enables and store lane replication.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_t;

    // Byte wins if both size selects are raised.
    function automatic size_t decode_size(input logic byte_access, input logic half_word);
        if (byte_access) begin
            return BYTE;
        end else if (half_word) begin
            return HALF;
        end
        return WORD;
    endfunction

    // offset is addr[30:31]; offset[1] is the address LSB.
    function automatic logic is_aligned(input size_t size, input logic [0:1] offset);
        case (size)
            BYTE:    return 1'b1;
            HALF:    return (offset[1] == 1'b0);
            default: return (offset == 2'd0);
        endcase
    endfunction

    // Big-endian lanes: be[0] covers bits [0:7], the lowest-addressed byte.
    function automatic logic [0:3] calc_be(input size_t size, input logic [0:1] offset);
        case (size)
            BYTE: begin
                case (offset)
                    2'd0:    return 4'b1000;
                    2'd1:    return 4'b0100;
                    2'd2:    return 4'b0010;
                    default: return 4'b0001;
                endcase
            end
            HALF:    return offset[0] ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [0:31] lane_wdata(input size_t size, input logic [0:31] wdata);
        case (size)
            BYTE:    return {4{wdata[24:31]}};
            HALF:    return {2{wdata[16:31]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load-path lane extraction: picks the addressed byte or halfword out of the
// memory word, right-justifies it and zero- or sign-extends it.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [0:31] mem_rdata,
    input  logic [1:0]  size,
    input  logic [0:1]  offset,
    input  logic        sign_extend,
    output logic [0:31] data
);

    logic [0:7]  byte_lane;
    logic [0:15] half_lane;

    always_comb begin
        byte_lane = mem_rdata[24:31];
        case (offset)
            2'd0:    byte_lane = mem_rdata[0:7];
            2'd1:    byte_lane = mem_rdata[8:15];
            2'd2:    byte_lane = mem_rdata[16:23];
            default: byte_lane = mem_rdata[24:31];
        endcase

        half_lane = offset[0] ? mem_rdata[16:31] : mem_rdata[0:15];

        case (size)
            BYTE:    data = {{24{sign_extend & byte_lane[0]}}, byte_lane};
            HALF:    data = {{16{sign_extend & half_lane[0]}}, half_lane};
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Processor data-memory access controller: IDLE/BUSY/DONE handshake with a
// word-wide backing memory, alignment checking and a bounded wait for mem_ready.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [0:31] addr,
    input  logic        write_enable,
    input  logic        byte_access,
    input  logic        half_word,
    input  logic        sign_extend,
    input  logic [0:31] wdata,
    output logic [0:31] rdata,
    output logic        stall,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [0:29] mem_addr,
    output logic [0:3]  mem_be,
    output logic [0:31] mem_wdata,
    input  logic [0:31] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  dbg_state
);

    // Handshake: the processor holds req_valid and its fields while stall=1;
    // the access completes on the DONE cycle (stall=0, rdata/err valid).
    // The memory side sees mem_req=1 with stable fields until mem_ready=1.

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          timeout;

    size_t         req_size;
    logic [0:1]    req_offset;
    logic          req_aligned;

    size_t         size_q;
    logic [0:1]    offset_q;
    logic          sign_extend_q;
    logic [0:31]   load_data;

    assign req_size    = decode_size(byte_access, half_word);
    assign req_offset  = addr[30:31];
    assign req_aligned = is_aligned(req_size, req_offset);
    assign timeout     = !mem_ready && (wait_cnt == CW'(MAX_WAIT - 1));
    assign dbg_state   = state;

    dmem_lane_align u_lane_align (
        .mem_rdata   (mem_rdata),
        .size        (size_q),
        .offset      (offset_q),
        .sign_extend (sign_extend_q),
        .data        (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    state_next = req_aligned ? BUSY : DONE;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ready || timeout) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt      <= '0;
            rdata         <= '0;
            err           <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            size_q        <= WORD;
            offset_q      <= '0;
            sign_extend_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_aligned) begin
                        wait_cnt      <= '0;
                        mem_req       <= 1'b1;
                        mem_we        <= write_enable;
                        mem_addr      <= addr[0:29];
                        mem_be        <= calc_be(req_size, req_offset);
                        mem_wdata     <= lane_wdata(req_size, wdata);
                        size_q        <= req_size;
                        offset_q      <= req_offset;
                        sign_extend_q <= sign_extend;
                    end else if (req_valid) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
                end
                BUSY: begin
                    // mem_ready beats the timeout when both land on the same cycle.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        err     <= 1'b0;
                        rdata   <= mem_we ? '0 : load_data;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timeout) begin
                            mem_req <= 1'b0;
                            err     <= 1'b1;
                            rdata   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
